// File: rtl/multi_channel_tick_divider.sv
// rtl/multi_channel_tick_divider.sv - NUM_CH programmable tick/divided-clock generator with shadowed periods.
// Optional PHASE_SYNC_EN adds sync_pulse to realign every channel.
module multi_channel_tick_divider #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 50_000,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
`ifdef PHASE_SYNC_EN
  input  logic              sync_pulse,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] pending
);

  localparam int NPAD = 1 << CH_W;

  logic [NPAD-1:0] pend_pad;
  logic            in_range;
  logic            xfer;
  logic            sync;

`ifdef PHASE_SYNC_EN
  assign sync = sync_pulse;
`else
  assign sync = 1'b0;
`endif

  // Pad pending to the full index space so any cfg_ch value selects a defined bit.
  always_comb begin
    pend_pad = '0;
    pend_pad[NUM_CH-1:0] = pending;
  end

  assign in_range  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign cfg_ready = in_range ? ~pend_pad[cfg_ch] : 1'b1;
  assign xfer      = cfg_valid & cfg_ready & in_range;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] shadow;
    logic             pend_q;
    logic             tick_q;
    logic             div_q;
    logic             hit;
    logic             tc;

    assign hit = xfer && (cfg_ch == CH_W'(g));
    assign tc  = enable[g] && (period != '0) && (cnt >= period - CNT_W'(1));

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        period <= CNT_W'(DEFAULT_PERIOD);
        shadow <= '0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        div_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (sync) begin
          cnt   <= '0;
          div_q <= 1'b0;
          if (pend_q) begin
            period <= shadow;
            pend_q <= 1'b0;
          end
        end else if (period == '0) begin
          // A stopped channel picks up a new period regardless of enable.
          cnt <= '0;
          if (pend_q) begin
            period <= shadow;
            pend_q <= 1'b0;
          end
        end else if (enable[g]) begin
          if (tc) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            div_q  <= ~div_q;
            if (pend_q) begin
              period <= shadow;
              pend_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // hit implies pend_q was clear, so this never races the apply above.
        if (hit) begin
          shadow <= cfg_period;
          pend_q <= 1'b1;
        end
      end
    end

    assign tick[g]    = tick_q;
    assign div_clk[g] = div_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_multi_channel_tick_divider.sv
// tb/tb_multi_channel_tick_divider.sv - directed and randomized checks against a cycle model.
module tb_multi_channel_tick_divider;
  localparam int NC  = 3;
  localparam int CW  = 2;
  localparam int W   = 16;
  localparam int DEF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [NC-1:0] enable = '0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_period = '0;
  logic          sync_pulse = 1'b0;
  logic          cfg_ready;
  logic [NC-1:0] tick, div_clk, pending;

  multi_channel_tick_divider #(
    .NUM_CH(NC), .CNT_W(W), .DEFAULT_PERIOD(DEF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef PHASE_SYNC_EN
    .sync_pulse(sync_pulse),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .tick(tick), .div_clk(div_clk), .pending(pending)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic obs_ready;
  logic exp_ready;

  int unsigned m_cnt [NC];
  int unsigned m_per [NC];
  int unsigned m_sh  [NC];
  bit          m_pend[NC];
  bit          m_tick[NC];
  bit          m_div [NC];

  function automatic logic model_ready();
    if (int'(cfg_ch) >= NC) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  function automatic logic [NC-1:0] m_vec(input int which);
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++)
      v[i] = (which == 0) ? m_tick[i] : (which == 1) ? m_div[i] : m_pend[i];
    return v;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NC; i++) begin
      bit take;
      if (reset) begin
        m_cnt[i] = 0; m_per[i] = DEF; m_sh[i] = 0;
        m_pend[i] = 0; m_tick[i] = 0; m_div[i] = 0;
        continue;
      end
      take = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
      m_tick[i] = 0;
      if (sync_pulse) begin
        m_cnt[i] = 0; m_div[i] = 0;
        if (m_pend[i]) begin m_per[i] = m_sh[i]; m_pend[i] = 0; end
      end else if (m_per[i] == 0) begin
        m_cnt[i] = 0;
        if (m_pend[i]) begin m_per[i] = m_sh[i]; m_pend[i] = 0; end
      end else if (enable[i]) begin
        if (m_cnt[i] + 1 >= m_per[i]) begin
          m_cnt[i] = 0; m_tick[i] = 1; m_div[i] = !m_div[i];
          if (m_pend[i]) begin m_per[i] = m_sh[i]; m_pend[i] = 0; end
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (take) begin m_sh[i] = cfg_period; m_pend[i] = 1; end
    end
  endtask

  task automatic step(input logic [NC-1:0] en, input logic v, input logic [CW-1:0] ch,
                      input logic [W-1:0] p, input logic rst, input logic sy);
    @(negedge clk);
    enable = en; cfg_valid = v; cfg_ch = ch; cfg_period = p; reset = rst; sync_pulse = sy;
    #1;
    obs_ready = cfg_ready;
    exp_ready = model_ready();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step('0, 1'b0, '0, '0, 1'b1, 1'b0);
    step('0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++; if (tick !== '0) begin n_bad++; $display("FAIL reset_tick got %b want 000", tick); end
    n_cmp++; if (div_clk !== '0) begin n_bad++; $display("FAIL reset_div got %b want 000", div_clk); end
    n_cmp++; if (pending !== '0) begin n_bad++; $display("FAIL reset_pending got %b want 000", pending); end
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", obs_ready); end
  endtask

  task automatic test_default_ticks();
    for (int c = 0; c < 12; c++) begin
      logic t_e, d_e;
      step('1, 1'b0, '0, '0, 1'b0, 1'b0);
      t_e = (c % 4 == 3);
      d_e = ((c + 1) / 4) % 2;
      n_cmp++;
      if (tick !== {NC{t_e}}) begin n_bad++; $display("FAIL default_tick c=%0d got %b want %b", c, tick, {NC{t_e}}); end
      n_cmp++;
      if (div_clk !== {NC{d_e}}) begin n_bad++; $display("FAIL default_div c=%0d got %b want %b", c, div_clk, {NC{d_e}}); end
    end
  endtask

  task automatic test_pending();
    bit got = 0;
    step('1, 1'b1, 2'd0, 16'd2, 1'b0, 1'b0);
    n_cmp++; if (pending[0] !== 1'b1) begin n_bad++; $display("FAIL pend_set got %b want 1", pending[0]); end
    for (int k = 0; k < 8 && !got; k++) begin
      step('1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL pend_ready got %b want 0", obs_ready); end
      got = tick[0];
      n_cmp++; if (pending[0] !== !got) begin n_bad++; $display("FAIL pend_hold got %b want %b", pending[0], !got); end
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL pend_timeout got no tick want tick within 8"); end
    for (int k = 0; k < 6; k++) begin
      step('1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (tick[0] !== (k % 2 == 1)) begin n_bad++; $display("FAIL pend_p2 k=%0d got %b want %b", k, tick[0], (k % 2 == 1)); end
    end
  endtask

  task automatic test_period_one();
    bit got = 0;
    logic held;
    step('1, 1'b1, 2'd0, 16'd1, 1'b0, 1'b0);
    for (int k = 0; k < 6 && !got; k++) begin
      step('1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      got = !pending[0];
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL p1_timeout got pending want applied"); end
    for (int k = 0; k < 4; k++) begin
      held = div_clk[0];
      step('1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      n_cmp++; if (tick[0] !== 1'b1) begin n_bad++; $display("FAIL p1_tick got %b want 1", tick[0]); end
      n_cmp++; if (div_clk[0] !== !held) begin n_bad++; $display("FAIL p1_div got %b want %b", div_clk[0], !held); end
    end
    held = div_clk[0];
    for (int k = 0; k < 5; k++) begin
      step(3'b110, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      n_cmp++; if (tick[0] !== 1'b0) begin n_bad++; $display("FAIL dis_tick got %b want 0", tick[0]); end
      n_cmp++; if (div_clk[0] !== held) begin n_bad++; $display("FAIL dis_div got %b want %b", div_clk[0], held); end
    end
    step('1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    n_cmp++; if (tick[0] !== 1'b1) begin n_bad++; $display("FAIL reen_tick got %b want 1", tick[0]); end
  endtask

  task automatic test_stop();
    bit got = 0;
    logic held;
    step('1, 1'b1, 2'd1, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !got; k++) begin
      step('1, 1'b0, 2'd1, '0, 1'b0, 1'b0);
      got = !pending[1];
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL stop_timeout got pending want applied"); end
    held = div_clk[1];
    for (int k = 0; k < 8; k++) begin
      step('1, 1'b0, 2'd1, '0, 1'b0, 1'b0);
      n_cmp++; if (tick[1] !== 1'b0) begin n_bad++; $display("FAIL stop_tick got %b want 0", tick[1]); end
      n_cmp++; if (div_clk[1] !== held) begin n_bad++; $display("FAIL stop_div got %b want %b", div_clk[1], held); end
    end
    step('1, 1'b1, 2'd1, 16'd3, 1'b0, 1'b0);
    n_cmp++; if (pending[1] !== 1'b1) begin n_bad++; $display("FAIL restart_pend got %b want 1", pending[1]); end
    step('1, 1'b0, 2'd1, '0, 1'b0, 1'b0);
    n_cmp++; if (pending[1] !== 1'b0) begin n_bad++; $display("FAIL restart_apply got %b want 0", pending[1]); end
    n_cmp++; if (tick[1] !== 1'b0) begin n_bad++; $display("FAIL restart_tick0 got %b want 0", tick[1]); end
    for (int k = 1; k <= 3; k++) begin
      step('1, 1'b0, 2'd1, '0, 1'b0, 1'b0);
      n_cmp++;
      if (tick[1] !== (k == 3)) begin n_bad++; $display("FAIL restart_tick k=%0d got %b want %b", k, tick[1], (k == 3)); end
    end
  endtask

  task automatic test_out_of_range_and_reset();
    step('1, 1'b1, 2'd3, 16'd7, 1'b0, 1'b0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL oor_ready got %b want 1", obs_ready); end
    n_cmp++; if (pending !== '0) begin n_bad++; $display("FAIL oor_pending got %b want 000", pending); end
    for (int k = 0; k < 4; k++) begin
      step('1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      n_cmp++; if (tick !== m_vec(0)) begin n_bad++; $display("FAIL oor_tick got %b want %b", tick, m_vec(0)); end
    end
    step(3'b110, 1'b1, 2'd0, 16'd9, 1'b0, 1'b0);
    n_cmp++; if (pending[0] !== 1'b1) begin n_bad++; $display("FAIL rp_set got %b want 1", pending[0]); end
    step(3'b110, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    n_cmp++; if (pending !== '0) begin n_bad++; $display("FAIL rp_clear got %b want 000", pending); end
    for (int c = 0; c < 4; c++) begin
      step('1, 1'b0, 2'd0, '0, 1'b0, 1'b0);
      n_cmp++; if (tick[0] !== (c == 3)) begin n_bad++; $display("FAIL rp_period c=%0d got %b want %b", c, tick[0], (c == 3)); end
    end
  endtask

`ifdef PHASE_SYNC_EN
  task automatic test_sync();
    step('0, 1'b0, '0, '0, 1'b1, 1'b0);
    step(3'b001, 1'b0, '0, '0, 1'b0, 1'b0);
    step(3'b001, 1'b0, '0, '0, 1'b0, 1'b0);
    step('1, 1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (tick !== '0) begin n_bad++; $display("FAIL sync_tick got %b want 000", tick); end
    n_cmp++; if (div_clk !== '0) begin n_bad++; $display("FAIL sync_div got %b want 000", div_clk); end
    for (int k = 0; k < 4; k++) begin
      step('1, 1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (tick !== {NC{k == 3}}) begin n_bad++; $display("FAIL sync_align k=%0d got %b want %b", k, tick, {NC{k == 3}}); end
    end
  endtask
`endif

  task automatic test_random();
    logic sy;
    step('0, 1'b0, '0, '0, 1'b1, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      sy = 1'b0;
`ifdef PHASE_SYNC_EN
      sy = ($urandom_range(0, 31) == 0);
`endif
      step(NC'($urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 7 : 0)),
           1'($urandom_range(0, 1)), CW'($urandom_range(0, 3)),
           W'($urandom_range(0, 5)), ($urandom_range(0, 63) == 0), sy);
      n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready n=%0d got %b want %b", n, obs_ready, exp_ready); end
      n_cmp++; if (tick !== m_vec(0)) begin n_bad++; $display("FAIL rnd_tick n=%0d got %b want %b", n, tick, m_vec(0)); end
      n_cmp++; if (div_clk !== m_vec(1)) begin n_bad++; $display("FAIL rnd_div n=%0d got %b want %b", n, div_clk, m_vec(1)); end
      n_cmp++; if (pending !== m_vec(2)) begin n_bad++; $display("FAIL rnd_pending n=%0d got %b want %b", n, pending, m_vec(2)); end
    end
  endtask

  initial begin
    test_reset();
    test_default_ticks();
    test_pending();
    test_period_one();
    test_stop();
    test_out_of_range_and_reset();
`ifdef PHASE_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
